// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: debounce FSM state
// encodings and the default timing parameters (10 ms at 100 MHz).
package btn_conditioner_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEFAULT_CNT_W           = 20;

   // IDLE/PRESS_CHK report the button as released, HELD/REL_CHK as pressed.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESS_CHK = 2'd1,
      ST_HELD      = 2'd2,
      ST_REL_CHK   = 2'd3
   } db_state_e;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button/control bundle between the raw push-buttons and the conditioned
// controls consumed by the register enable and the output mux.
interface btn_conditioner_if;

   logic btn0;        // raw load-request button
   logic btn1;        // raw select-toggle button
   logic load_pulse;  // one-cycle register enable per accepted btn0 press
   logic sel;         // mux select, toggled per accepted btn1 press
   logic btn0_db;     // debounced btn0 level
   logic btn1_db;     // debounced btn1 level

   // Side that owns the buttons and consumes the conditioned controls.
   modport master (
      output btn0, btn1,
      input  load_pulse, sel, btn0_db, btn1_db
   );

   // The conditioner itself.
   modport slave (
      input  btn0, btn1,
      output load_pulse, sel, btn0_db, btn1_db
   );

endinterface

// File: rtl/btn_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser feeding a four-state debounce
// FSM. A level change is accepted only after DEBOUNCE_CYCLES consecutive
// stable samples; any contrary sample restarts qualification from zero.
module debounce_channel
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,   // asynchronous, bouncy
   output logic db,        // debounced level, registered
   output logic press      // high in the cycle before db rises (accepted press)
);

   // Terminal count: the counter is compared before it increments, so it
   // never exceeds this value and can never wrap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;
   logic             press_d;

   // Next-state, counter and debounced-level logic of the debounce FSM.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      press_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s2_q) begin
               state_d = ST_PRESS_CHK;
               cnt_d   = '0;
            end
         end
         ST_PRESS_CHK: begin
            if (!s2_q) begin
               state_d = ST_IDLE;          // bounce rejected
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HELD;
               cnt_d   = '0;
               db_d    = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HELD: begin
            if (!s2_q) begin
               state_d = ST_REL_CHK;
               cnt_d   = '0;
            end
         end
         ST_REL_CHK: begin
            if (s2_q) begin
               state_d = ST_HELD;          // release bounce, still held
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               db_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            db_d    = 1'b0;
         end
      endcase
   end

   // Synchroniser and FSM registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         db_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so s2_q captures the previous s1_q; with '='
         // the two synchroniser stages would collapse into one.
         s1_q    <= btn_raw;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   assign db    = db_q;
   // Decoded from registered state only; the top registers it again so the
   // strobe lands on the same edge as db rising.
   assign press = press_d;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two independent debounce channels, a one-cycle
// load strobe from button 0 and a press-toggled mux select from button 1.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   btn_conditioner_if.slave   bus
);

   logic press0, press1;
   logic db0, db1;
   logic load_pulse_q, load_pulse_d;
   logic sel_q, sel_d;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_ch0 (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (bus.btn0),
      .db      (db0),
      .press   (press0)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_ch1 (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (bus.btn1),
      .db      (db1),
      .press   (press1)
   );

   // Load strobe follows each accepted btn0 press; sel flips per btn1 press.
   always_comb begin
      load_pulse_d = press0;
      sel_d        = sel_q ^ press1;
   end

   // Output registers for the load strobe and the select level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_pulse_q <= 1'b0;
         sel_q        <= 1'b0;
      end else begin
         load_pulse_q <= load_pulse_d;
         sel_q        <= sel_d;
      end
   end

   assign bus.load_pulse = load_pulse_q;
   assign bus.sel        = sel_q;
   assign bus.btn0_db    = db0;
   assign bus.btn1_db    = db1;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4. Stimulus
// pushes the expected output events (edge number and value); a monitor on
// the falling clock edge pops and compares them as the DUT produces them.
module tb_btn_conditioner;

   localparam int D   = 4;
   localparam int LAT = D + 3;   // drive before edge k -> event after edge k+2+D

   typedef struct {
      int   edge_no;
      logic val;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   logic mon_en = 1'b0;
   logic exp_sel = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   ev_t load_q[$];
   ev_t sel_q[$];
   ev_t db0_q[$];
   ev_t db1_q[$];

   btn_conditioner_if bus ();

   btn_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;

   // Edge counter: after posedge n, cyc == n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int act, input int exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp_v, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called on the falling edge where the raw input changes.
   task automatic exp_press0();
      load_q.push_back('{edge_no: cyc + LAT, val: 1'b1});
      db0_q.push_back('{edge_no: cyc + LAT, val: 1'b1});
   endtask

   task automatic exp_release0();
      db0_q.push_back('{edge_no: cyc + LAT, val: 1'b0});
   endtask

   task automatic exp_press1();
      exp_sel = ~exp_sel;
      sel_q.push_back('{edge_no: cyc + LAT, val: exp_sel});
      db1_q.push_back('{edge_no: cyc + LAT, val: 1'b1});
   endtask

   task automatic exp_release1();
      db1_q.push_back('{edge_no: cyc + LAT, val: 1'b0});
   endtask

   // Monitor: compares every observed output event against the scoreboard.
   initial begin
      logic prev_sel, prev_db0, prev_db1;
      ev_t  e;
      prev_sel = 1'b0;
      prev_db0 = 1'b0;
      prev_db1 = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            if (bus.load_pulse) begin
               if (load_q.size() == 0) check("load_spurious", bus.load_pulse, 0);
               else begin
                  e = load_q.pop_front();
                  check("load_edge", cyc, e.edge_no);
               end
            end
            if (bus.sel !== prev_sel) begin
               if (sel_q.size() == 0) check("sel_spurious", bus.sel, prev_sel);
               else begin
                  e = sel_q.pop_front();
                  check("sel_edge", cyc, e.edge_no);
                  check("sel_val", bus.sel, e.val);
               end
            end
            if (bus.btn0_db !== prev_db0) begin
               if (db0_q.size() == 0) check("db0_spurious", bus.btn0_db, prev_db0);
               else begin
                  e = db0_q.pop_front();
                  check("db0_edge", cyc, e.edge_no);
                  check("db0_val", bus.btn0_db, e.val);
               end
            end
            if (bus.btn1_db !== prev_db1) begin
               if (db1_q.size() == 0) check("db1_spurious", bus.btn1_db, prev_db1);
               else begin
                  e = db1_q.pop_front();
                  check("db1_edge", cyc, e.edge_no);
                  check("db1_val", bus.btn1_db, e.val);
               end
            end
         end
         prev_sel = bus.sel;
         prev_db0 = bus.btn0_db;
         prev_db1 = bus.btn1_db;
      end
   end

   // Stimulus.
   initial begin
      rst      = 1'b1;
      bus.btn0 = 1'b0;
      bus.btn1 = 1'b0;
      tick(3);
      check("rst_load", bus.load_pulse, 0);
      check("rst_sel",  bus.sel,        0);
      check("rst_db0",  bus.btn0_db,    0);
      check("rst_db1",  bus.btn1_db,    0);
      rst    = 1'b0;
      mon_en = 1'b1;
      tick(3);

      // Clean btn0 press, held 20 cycles.
      bus.btn0 = 1'b1; exp_press0();
      tick(20);
      bus.btn0 = 1'b0; exp_release0();
      tick(15);

      // Bounce: high/low every 2 cycles for 30 cycles, never accepted.
      for (int i = 0; i < 15; i++) begin
         bus.btn0 = (i % 2 == 0);
         tick(2);
      end
      bus.btn0 = 1'b0;
      tick(15);

      // Threshold: D high samples rejected, D+1 accepted.
      bus.btn0 = 1'b1;
      tick(D);
      bus.btn0 = 1'b0;
      tick(15);
      bus.btn0 = 1'b1; exp_press0();
      tick(D + 1);
      bus.btn0 = 1'b0; exp_release0();
      tick(15);

      // sel toggling: three clean btn1 presses, 20 cycles apart.
      for (int i = 0; i < 3; i++) begin
         bus.btn1 = 1'b1; exp_press1();
         tick(10);
         bus.btn1 = 1'b0; exp_release1();
         tick(10);
      end
      tick(10);

      // Reset while btn1 sits in PRESS_CHK with cnt=2 and sel=1.
      check("sel_before_rst", bus.sel, 1);
      bus.btn1 = 1'b1;
      tick(5);
      #2 rst = 1'b1;
      #1;
      check("async_rst_sel",  bus.sel,        0);
      check("async_rst_load", bus.load_pulse, 0);
      check("async_rst_db0",  bus.btn0_db,    0);
      check("async_rst_db1",  bus.btn1_db,    0);
      exp_sel = 1'b0;
      tick(2);
      rst = 1'b0; exp_press1();
      tick(12);
      bus.btn1 = 1'b0; exp_release1();
      tick(15);

      // Simultaneous presses on both buttons.
      bus.btn0 = 1'b1; bus.btn1 = 1'b1;
      exp_press0(); exp_press1();
      tick(10);
      bus.btn0 = 1'b0; bus.btn1 = 1'b0;
      exp_release0(); exp_release1();
      tick(15);

      // Release bounce while held: low 2, high 1, then steady low.
      bus.btn0 = 1'b1; exp_press0();
      tick(10);
      bus.btn0 = 1'b0;
      tick(2);
      bus.btn0 = 1'b1;
      tick(1);
      bus.btn0 = 1'b0; exp_release0();
      tick(15);

      // Every expected event must have been consumed.
      check("load_q_empty", load_q.size(), 0);
      check("sel_q_empty",  sel_q.size(),  0);
      check("db0_q_empty",  db0_q.size(),  0);
      check("db1_q_empty",  db1_q.size(),  0);
      check("final_sel",    bus.sel,       exp_sel);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
